eth_frame_gen: RTL and testbench

Ethernet test-frame source for the 10G simulation environment. It drives a 64-bit AXI-Stream master that feeds the bridge's RX slave port. It emits a programmable number of fixed-length frames with a fixed L2 header, a 32-bit sequence number and a deterministic payload, honours `tready` backpressure, and inserts a configurable idle gap between frames.

---
 rtl/eth_sim_pkg.sv | 34 +++
 rtl/eth_frame_gen_if.sv | 14 +
 rtl/eth_beat_fmt.sv | 40 ++++
 rtl/eth_frame_gen.sv | 155 +++++++++++++++
 tb/tb_eth_frame_gen.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/eth_sim_pkg.sv
// Shared types, limits and helpers for the simulation Ethernet frame source.
package eth_sim_pkg;

  localparam int unsigned ETH_MIN_LEN = 60;
  localparam int unsigned ETH_MAX_LEN = 9600;
  localparam int unsigned DATA_W      = 64;
  localparam int unsigned KEEP_W      = 8;
  localparam int unsigned BEAT_W      = 11;  // up to 1200 beats per frame
  localparam int unsigned LEN_W       = BEAT_W + 3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_GAP
  } gen_state_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [KEEP_W-1:0] keep;
    logic              last;
  } axis_beat_t;

  function automatic logic [KEEP_W-1:0] keep_from_rem(input logic [2:0] rem);
    if (rem == 3'd0) keep_from_rem = 8'hFF;
    else             keep_from_rem = 8'((9'd1 << rem) - 9'd1);
  endfunction

  function automatic logic [LEN_W-1:0] clamp_len(input logic [15:0] len);
    if (len < 16'(ETH_MIN_LEN))      clamp_len = LEN_W'(ETH_MIN_LEN);
    else if (len > 16'(ETH_MAX_LEN)) clamp_len = LEN_W'(ETH_MAX_LEN);
    else                             clamp_len = len[LEN_W-1:0];
  endfunction

endpackage

// File: rtl/eth_frame_gen_if.sv
// 64-bit AXI-Stream link between the frame source and its sink.
interface eth_frame_gen_if;
  import eth_sim_pkg::*;

  logic              tvalid;
  logic              tready;
  logic [DATA_W-1:0] tdata;
  logic [KEEP_W-1:0] tkeep;
  logic              tlast;
  logic              tuser;

  modport master (output tvalid, tdata, tkeep, tlast, tuser, input tready);
  modport slave  (input tvalid, tdata, tkeep, tlast, tuser, output tready);
endinterface

// File: rtl/eth_beat_fmt.sv
// Combinational beat builder: beat index + frame length + sequence -> tdata/tkeep/tlast.
module eth_beat_fmt
  import eth_sim_pkg::*;
#(
  parameter logic [47:0] DST_MAC   = 48'hFFFF_FFFF_FFFF,
  parameter logic [47:0] SRC_MAC   = 48'h02_00_00_00_00_01,
  parameter logic [15:0] ETHERTYPE = 16'h88B5
) (
  input  logic [BEAT_W-1:0] beat_idx,
  input  logic [LEN_W-1:0]  len,
  input  logic [31:0]       seq,
  output axis_beat_t        beat
);

  localparam logic [111:0] HDR = {DST_MAC, SRC_MAC, ETHERTYPE};

  // Byte n of the frame: header, then MSB-first sequence, then n[7:0] payload.
  function automatic logic [7:0] byte_at(input logic [LEN_W-1:0] n, input logic [31:0] s);
    int idx;
    if (n < LEN_W'(14)) begin
      idx     = 13 - int'(n);
      byte_at = HDR[8*idx +: 8];
    end else if (n < LEN_W'(18)) begin
      idx     = 17 - int'(n);
      byte_at = s[8*idx +: 8];
    end else begin
      byte_at = n[7:0];
    end
  endfunction

  always_comb begin
    beat      = '0;
    beat.last = (beat_idx == BEAT_W'((len - LEN_W'(1)) >> 3));
    beat.keep = beat.last ? keep_from_rem(len[2:0]) : 8'hFF;
    for (int i = 0; i < int'(KEEP_W); i++) begin
      if (beat.keep[i]) beat.data[8*i +: 8] = byte_at({beat_idx, 3'(i)}, seq);
    end
  end

endmodule

// File: rtl/eth_frame_gen.sv
// Ethernet test-frame source: counted/unlimited runs of fixed-length frames with idle gaps.
module eth_frame_gen
  import eth_sim_pkg::*;
#(
  parameter logic [47:0] DST_MAC    = 48'hFFFF_FFFF_FFFF,
  parameter logic [47:0] SRC_MAC    = 48'h02_00_00_00_00_01,
  parameter logic [15:0] ETHERTYPE  = 16'h88B5,
  parameter int unsigned IFG_CYCLES = 4
) (
  input  logic                   clk156,
  input  logic                   rst,
  input  logic                   start,
  input  logic [15:0]            frame_len,
  input  logic [31:0]            frame_cnt,
  input  logic                   stop,
  eth_frame_gen_if.master        m_axis_tx,
  output logic                   busy,
  output logic [31:0]            frames_sent
);

  localparam int unsigned GAP_W = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;

  gen_state_t        state_q, state_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [31:0]       cnt_q, cnt_d;
  logic [31:0]       sent_q, sent_d;
  logic              stop_pend_q, stop_pend_d;
  logic [GAP_W-1:0]  gap_q, gap_d;

  logic              tvalid_q, tvalid_d;
  logic [DATA_W-1:0] tdata_q, tdata_d;
  logic [KEEP_W-1:0] tkeep_q, tkeep_d;
  logic              tlast_q, tlast_d;
  logic              busy_q, busy_d;

  logic              acc;
  axis_beat_t        fmt_beat;

  assign acc = tvalid_q & m_axis_tx.tready;

  // Outputs are built from the next-cycle beat so they can be registered.
  eth_beat_fmt #(
    .DST_MAC  (DST_MAC),
    .SRC_MAC  (SRC_MAC),
    .ETHERTYPE(ETHERTYPE)
  ) u_fmt (
    .beat_idx(beat_d),
    .len     (len_d),
    .seq     (sent_d),
    .beat    (fmt_beat)
  );

  always_ff @(posedge clk156) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      beat_q      <= '0;
      len_q       <= '0;
      cnt_q       <= '0;
      sent_q      <= '0;
      stop_pend_q <= 1'b0;
      gap_q       <= '0;
      tvalid_q    <= 1'b0;
      tdata_q     <= '0;
      tkeep_q     <= '0;
      tlast_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      sent_q      <= sent_d;
      stop_pend_q <= stop_pend_d;
      gap_q       <= gap_d;
      tvalid_q    <= tvalid_d;
      tdata_q     <= tdata_d;
      tkeep_q     <= tkeep_d;
      tlast_q     <= tlast_d;
      busy_q      <= busy_d;
    end
  end

  // Next-state, beat/gap counters and run bookkeeping.
  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    sent_d      = sent_q;
    stop_pend_d = stop_pend_q;
    gap_d       = gap_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          len_d       = clamp_len(frame_len);
          cnt_d       = frame_cnt;
          sent_d      = '0;
          beat_d      = '0;
          stop_pend_d = stop;  // start+stop together yields a single frame
          state_d     = ST_SEND;
        end
      end
      ST_SEND: begin
        if (stop) stop_pend_d = 1'b1;
        if (acc) begin
          if (tlast_q) begin
            beat_d = '0;
            sent_d = sent_q + 32'd1;
            gap_d  = '0;
            if (stop_pend_q || stop || (cnt_q != 32'd0 && sent_q + 32'd1 == cnt_q))
              state_d = ST_IDLE;
            else if (IFG_CYCLES == 0)
              state_d = ST_SEND;
            else
              state_d = ST_GAP;
          end else begin
            beat_d = beat_q + BEAT_W'(1);
          end
        end
      end
      ST_GAP: begin
        if (stop) stop_pend_d = 1'b1;
        gap_d = gap_q + GAP_W'(1);
        if (gap_q == GAP_W'(IFG_CYCLES - 1))
          state_d = (stop_pend_q || stop) ? ST_IDLE : ST_SEND;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output values for the coming cycle; lanes are zero whenever tvalid is low.
  always_comb begin
    tvalid_d = 1'b0;
    tdata_d  = '0;
    tkeep_d  = '0;
    tlast_d  = 1'b0;
    busy_d   = (state_d != ST_IDLE);
    if (state_d == ST_SEND) begin
      tvalid_d = 1'b1;
      tdata_d  = fmt_beat.data;
      tkeep_d  = fmt_beat.keep;
      tlast_d  = fmt_beat.last;
    end
  end

  assign m_axis_tx.tvalid = tvalid_q;
  assign m_axis_tx.tdata  = tdata_q;
  assign m_axis_tx.tkeep  = tkeep_q;
  assign m_axis_tx.tlast  = tlast_q;
  assign m_axis_tx.tuser  = 1'b0;
  assign busy             = busy_q;
  assign frames_sent      = sent_q;

endmodule

// File: tb/tb_eth_frame_gen.sv
// Directed bench for eth_frame_gen: beat capture with a byte-level frame model.
module tb_eth_frame_gen;

  logic        clk156 = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [15:0] frame_len = '0;
  logic [31:0] frame_cnt = '0;
  logic        busy;
  logic [31:0] frames_sent;

  eth_frame_gen_if axis();

  eth_frame_gen dut (
    .clk156     (clk156),
    .rst        (rst),
    .start      (start),
    .frame_len  (frame_len),
    .frame_cnt  (frame_cnt),
    .stop       (stop),
    .m_axis_tx  (axis),
    .busy       (busy),
    .frames_sent(frames_sent)
  );

  always #3 clk156 = ~clk156;

  int checks = 0;
  int errors = 0;

  int          n_frames, bad_data, bad_stable, bad_len, gap_bad, gaps_seen, cyc;
  logic [7:0]  last_keep;
  logic [63:0] b0_data, b1_data;
  logic [31:0] seqs[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference frame byte for default parameters.
  function automatic logic [7:0] model_byte(input int n, input int seq);
    logic [31:0] s;
    s = seq;
    if (n < 6)   return 8'hFF;
    if (n == 6)  return 8'h02;
    if (n < 11)  return 8'h00;
    if (n == 11) return 8'h01;
    if (n == 12) return 8'h88;
    if (n == 13) return 8'hB5;
    if (n < 18)  return 8'(s >> (8 * (17 - n)));
    return 8'(n);
  endfunction

  task automatic do_start(input logic [15:0] l, input logic [31:0] c);
    frame_len = l;
    frame_cnt = c;
    start     = 1'b1;
    @(posedge clk156); #1;
    start = 1'b0;
  endtask

  // Watch the stream until busy drops (bounded), tallying protocol and content errors.
  task automatic capture(input int len, input int ready_pct, input int budget,
                         input int exp_gap, input int stop_seq, input bit poke);
    int beat, idle, exp_beats, n;
    bit stall, in_gap, stop_done;
    logic [63:0] pd;
    logic [7:0]  pk, eb;
    logic        pl;
    logic [31:0] sq;
    n_frames = 0; bad_data = 0; bad_stable = 0; bad_len = 0; gap_bad = 0; gaps_seen = 0;
    cyc = 0; last_keep = '0; b0_data = '0; b1_data = '0; seqs.delete();
    beat = 0; idle = 0; stall = 0; in_gap = 0; stop_done = 0; sq = '0;
    pd = '0; pk = '0; pl = 1'b0;
    exp_beats = (len + 7) / 8;
    while (busy === 1'b1 && cyc < budget) begin
      axis.tready = (ready_pct >= 100) ? 1'b1 : ($urandom_range(99) < ready_pct);
      start = 1'b0;
      stop  = 1'b0;
      if (poke && cyc == 1) begin
        start = 1'b1; frame_len = 16'd200; frame_cnt = 32'd1;
      end
      if (!stop_done && n_frames == stop_seq && beat == 2) begin
        stop = 1'b1; stop_done = 1'b1;
      end
      if (axis.tvalid === 1'b1) begin
        if (stall && (axis.tdata !== pd || axis.tkeep !== pk || axis.tlast !== pl)) bad_stable++;
        if (in_gap) begin
          gaps_seen++;
          if (idle != exp_gap) gap_bad++;
          in_gap = 1'b0;
        end
        for (int i = 0; i < 8; i++) begin
          n  = beat * 8 + i;
          eb = (n < len) ? model_byte(n, n_frames) : 8'h00;
          if (axis.tdata[8*i +: 8] !== eb || axis.tkeep[i] !== (n < len)) bad_data++;
        end
        if (axis.tlast !== (beat == exp_beats - 1)) bad_data++;
        if (n_frames == 0 && beat == 0) b0_data = axis.tdata;
        if (n_frames == 0 && beat == 1) b1_data = axis.tdata;
        if (beat == 1) sq[31:16] = {axis.tdata[55:48], axis.tdata[63:56]};
        if (beat == 2) sq[15:0]  = {axis.tdata[7:0], axis.tdata[15:8]};
        if (axis.tready) begin
          if (beat == 2) seqs.push_back(sq);
          if (axis.tlast === 1'b1) begin
            if (beat + 1 != exp_beats) bad_len++;
            last_keep = axis.tkeep;
            n_frames++;
            beat   = 0;
            in_gap = 1'b1;
            idle   = 0;
          end else begin
            beat++;
          end
          stall = 1'b0;
        end else begin
          stall = 1'b1;
          pd = axis.tdata; pk = axis.tkeep; pl = axis.tlast;
        end
      end else begin
        if (stall || beat != 0) bad_stable++;
        idle++;
      end
      @(posedge clk156); #1;
      cyc++;
    end
    start = 1'b0;
    stop  = 1'b0;
    axis.tready = 1'b1;
    check("run_ends", 64'(busy), 64'd0);
  endtask

  initial begin
    int tv;
    axis.tready = 1'b1;
    repeat (3) @(posedge clk156);
    #1;
    check("rst_tvalid", 64'(axis.tvalid), 64'd0);
    check("rst_tdata", axis.tdata, 64'd0);
    check("rst_tkeep", 64'(axis.tkeep), 64'd0);
    check("rst_tlast", 64'(axis.tlast), 64'd0);
    check("rst_tuser", 64'(axis.tuser), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_frames", 64'(frames_sent), 64'd0);
    rst = 1'b0;
    @(posedge clk156); #1;

    // Minimum frame, single shot
    do_start(16'd60, 32'd1);
    check("lat_busy", 64'(busy), 64'd1);
    check("lat_tvalid", 64'(axis.tvalid), 64'd1);
    capture(60, 100, 100, 4, -1, 1'b0);
    check("t1_frames", 64'(n_frames), 64'd1);
    check("t1_data", 64'(bad_data), 64'd0);
    check("t1_beats", 64'(bad_len), 64'd0);
    check("t1_beat0", b0_data, 64'h0002_FFFF_FFFF_FFFF);
    check("t1_beat1", b1_data, 64'h0000_B588_0100_0000);
    check("t1_lastkeep", 64'(last_keep), 64'h0F);
    check("t1_sent", 64'(frames_sent), 64'd1);
    check("t1_tvalid_off", 64'(axis.tvalid), 64'd0);

    // Three 64-byte frames with the default gap
    do_start(16'd64, 32'd3);
    capture(64, 100, 200, 4, -1, 1'b0);
    check("t2_frames", 64'(n_frames), 64'd3);
    check("t2_data", 64'(bad_data), 64'd0);
    check("t2_lastkeep", 64'(last_keep), 64'hFF);
    check("t2_gaps", 64'(gaps_seen), 64'd2);
    check("t2_gap_len", 64'(gap_bad), 64'd0);
    check("t2_cycles", 64'(cyc), 64'd32);
    check("t2_nseq", 64'(seqs.size()), 64'd3);
    if (seqs.size() == 3) begin
      check("t2_seq0", 64'(seqs[0]), 64'd0);
      check("t2_seq1", 64'(seqs[1]), 64'd1);
      check("t2_seq2", 64'(seqs[2]), 64'd2);
    end
    check("t2_sent", 64'(frames_sent), 64'd3);

    // Random backpressure
    do_start(16'd100, 32'd4);
    capture(100, 50, 3000, 4, -1, 1'b0);
    check("t3_frames", 64'(n_frames), 64'd4);
    check("t3_data", 64'(bad_data), 64'd0);
    check("t3_stable", 64'(bad_stable), 64'd0);
    check("t3_beats", 64'(bad_len), 64'd0);
    check("t3_lastkeep", 64'(last_keep), 64'h0F);
    check("t3_gap_len", 64'(gap_bad), 64'd0);
    check("t3_sent", 64'(frames_sent), 64'd4);
    check("t3_nseq", 64'(seqs.size()), 64'd4);
    if (seqs.size() == 4) check("t3_seq3", 64'(seqs[3]), 64'd3);

    // Length clamp, low side
    do_start(16'd10, 32'd1);
    capture(60, 100, 100, 4, -1, 1'b0);
    check("t4_frames", 64'(n_frames), 64'd1);
    check("t4_beats", 64'(bad_len), 64'd0);
    check("t4_data", 64'(bad_data), 64'd0);
    check("t4_lastkeep", 64'(last_keep), 64'h0F);

    // Length clamp, high side
    do_start(16'd20000, 32'd1);
    capture(9600, 100, 1400, 4, -1, 1'b0);
    check("t5_frames", 64'(n_frames), 64'd1);
    check("t5_beats", 64'(bad_len), 64'd0);
    check("t5_cycles", 64'(cyc), 64'd1200);
    check("t5_data", 64'(bad_data), 64'd0);
    check("t5_lastkeep", 64'(last_keep), 64'hFF);

    // Unlimited run stopped during the frame carrying seq 4
    do_start(16'd60, 32'd0);
    capture(60, 100, 300, 4, 4, 1'b0);
    check("t6_frames", 64'(n_frames), 64'd5);
    check("t6_data", 64'(bad_data), 64'd0);
    check("t6_sent", 64'(frames_sent), 64'd5);
    tv = 0;
    repeat (10) begin
      if (axis.tvalid !== 1'b0) tv++;
      @(posedge clk156); #1;
    end
    check("t6_quiet", 64'(tv), 64'd0);

    // start while busy must be ignored
    do_start(16'd60, 32'd2);
    capture(60, 100, 200, 4, -1, 1'b1);
    check("t7_frames", 64'(n_frames), 64'd2);
    check("t7_data", 64'(bad_data), 64'd0);
    check("t7_sent", 64'(frames_sent), 64'd2);

    // Reset in the middle of a frame
    do_start(16'd60, 32'd0);
    tv = 0;
    while (frames_sent != 32'd2 && tv < 200) begin
      @(posedge clk156); #1;
      tv++;
    end
    check("t8_reach", 64'(frames_sent), 64'd2);
    while (axis.tvalid !== 1'b1 && tv < 220) begin
      @(posedge clk156); #1;
      tv++;
    end
    repeat (3) @(posedge clk156);
    #1;
    check("t8_midframe", 64'(axis.tvalid), 64'd1);
    rst = 1'b1;
    @(posedge clk156); #1;
    rst = 1'b0;
    check("t8_tvalid", 64'(axis.tvalid), 64'd0);
    check("t8_sent", 64'(frames_sent), 64'd0);
    check("t8_busy", 64'(busy), 64'd0);
    check("t8_tdata", axis.tdata, 64'd0);
    do_start(16'd60, 32'd1);
    capture(60, 100, 100, 4, -1, 1'b0);
    check("t8_frames", 64'(n_frames), 64'd1);
    check("t8_data", 64'(bad_data), 64'd0);
    check("t8_nseq", 64'(seqs.size()), 64'd1);
    if (seqs.size() == 1) check("t8_seq0", 64'(seqs[0]), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
